// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// The sequencer side is the master; the datapath/memory side is the slave.
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;

    logic             MemRd;
    logic             MemWr;
    logic             IRWr;
    logic             PCWr;
    logic [1:0]       PCSrc;
    logic [1:0]       EXTOp;
    logic             ALUSrcB;
    logic [1:0]       ALUOp;
    logic             RegWr;
    logic [1:0]       RegDst;
    logic [1:0]       WDSel;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  op, funct, zero, mem_ready,
        output MemRd, MemWr, IRWr, PCWr, PCSrc, EXTOp, ALUSrcB, ALUOp,
               RegWr, RegDst, WDSel, illegal, state, retired
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  MemRd, MemWr, IRWr, PCWr, PCSrc, EXTOp, ALUSrcB, ALUOp,
               RegWr, RegDst, WDSel, illegal, state, retired
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// stallable shared memory port and a retired-instruction counter.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_JR, I_NOP, I_ORI, I_LUI,
        I_LW, I_SW, I_BEQ, I_JAL, I_ILL
    } instr_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_SLL   = 6'b000000;

    localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;
    localparam logic [1:0] ALU_ADD  = 2'd0, ALU_SUB  = 2'd1, ALU_OR = 2'd2, ALU_PASS = 2'd3;
    localparam logic [1:0] PC_SEQ   = 2'd0, PC_BR    = 2'd1, PC_J   = 2'd2, PC_REG   = 2'd3;
    localparam logic [1:0] DST_RT   = 2'd0, DST_RD   = 2'd1, DST_RA = 2'd2;
    localparam logic [1:0] WD_ALU   = 2'd0, WD_MEM   = 2'd1, WD_PC  = 2'd2;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    instr_t           instr;

    logic [1:0]       ext_op, alu_op, pc_src, reg_dst, wd_sel;
    logic             alu_src_b, writes_reg;

    always_comb begin : decode
        instr = I_ILL;
        case (bus.op)
            OP_RTYPE: begin
                case (bus.funct)
                    FN_ADDU: instr = I_ADDU;
                    FN_SUBU: instr = I_SUBU;
                    FN_JR:   instr = I_JR;
                    FN_SLL:  instr = I_NOP;
                    default: instr = I_ILL;
                endcase
            end
            OP_ORI:  instr = I_ORI;
            OP_LUI:  instr = I_LUI;
            OP_LW:   instr = I_LW;
            OP_SW:   instr = I_SW;
            OP_BEQ:  instr = I_BEQ;
            OP_JAL:  instr = I_JAL;
            default: instr = I_ILL;
        endcase
    end

    // Selects depend only on the instruction, so they stay stable from EXEC to WB.
    always_comb begin : selects
        ext_op     = EXT_ZERO;
        alu_op     = ALU_ADD;
        alu_src_b  = 1'b0;
        pc_src     = PC_SEQ;
        reg_dst    = DST_RT;
        wd_sel     = WD_ALU;
        writes_reg = 1'b0;
        case (instr)
            I_ADDU: begin
                reg_dst    = DST_RD;
                writes_reg = 1'b1;
            end
            I_SUBU: begin
                alu_op     = ALU_SUB;
                reg_dst    = DST_RD;
                writes_reg = 1'b1;
            end
            I_ORI: begin
                alu_op     = ALU_OR;
                alu_src_b  = 1'b1;
                writes_reg = 1'b1;
            end
            I_LUI: begin
                ext_op     = EXT_LUI;
                alu_op     = ALU_PASS;
                alu_src_b  = 1'b1;
                writes_reg = 1'b1;
            end
            I_LW: begin
                ext_op     = EXT_SIGN;
                alu_src_b  = 1'b1;
                wd_sel     = WD_MEM;
                writes_reg = 1'b1;
            end
            I_SW: begin
                ext_op     = EXT_SIGN;
                alu_src_b  = 1'b1;
            end
            I_BEQ: begin
                ext_op     = EXT_SIGN;
                alu_op     = ALU_SUB;
                pc_src     = PC_BR;
            end
            I_JAL: begin
                pc_src     = PC_J;
                reg_dst    = DST_RA;
                wd_sel     = WD_PC;
                writes_reg = 1'b1;
            end
            I_JR: begin
                pc_src     = PC_REG;
            end
            default: ;
        endcase
    end

    always_comb begin : fsm
        state_d     = state_q;
        retire      = 1'b0;
        bus.MemRd   = 1'b0;
        bus.MemWr   = 1'b0;
        bus.IRWr    = 1'b0;
        bus.PCWr    = 1'b0;
        bus.RegWr   = 1'b0;
        bus.illegal = 1'b0;
        bus.PCSrc   = PC_SEQ;
        bus.EXTOp   = EXT_ZERO;
        bus.ALUSrcB = 1'b0;
        bus.ALUOp   = ALU_ADD;
        bus.RegDst  = DST_RT;
        bus.WDSel   = WD_ALU;

        // Reset silences every strobe and select, whatever state is held.
        if (!reset) begin
            if (state_q == EXEC || state_q == MEM || state_q == WB) begin
                bus.PCSrc   = pc_src;
                bus.EXTOp   = ext_op;
                bus.ALUSrcB = alu_src_b;
                bus.ALUOp   = alu_op;
                bus.RegDst  = reg_dst;
                bus.WDSel   = wd_sel;
            end

            case (state_q)
                FETCH: begin
                    bus.MemRd = 1'b1;
                    if (bus.mem_ready) begin
                        bus.IRWr = 1'b1;
                        bus.PCWr = 1'b1;
                        state_d  = DECODE;
                    end
                end
                DECODE: begin
                    if (instr == I_ILL) begin
                        bus.illegal = 1'b1;
                        state_d     = FETCH;
                    end else begin
                        state_d     = EXEC;
                    end
                end
                EXEC: begin
                    case (instr)
                        I_ADDU, I_SUBU, I_ORI, I_LUI: state_d = WB;
                        I_LW, I_SW:                   state_d = MEM;
                        I_BEQ: begin
                            bus.PCWr = bus.zero;
                            state_d  = FETCH;
                            retire   = 1'b1;
                        end
                        I_JAL: begin
                            bus.PCWr = 1'b1;
                            state_d  = WB;
                        end
                        I_JR: begin
                            bus.PCWr = 1'b1;
                            state_d  = FETCH;
                            retire   = 1'b1;
                        end
                        I_NOP: begin
                            state_d  = FETCH;
                            retire   = 1'b1;
                        end
                        default: state_d = FETCH;
                    endcase
                end
                MEM: begin
                    if (instr == I_LW) begin
                        bus.MemRd = 1'b1;
                        if (bus.mem_ready) state_d = WB;
                    end else if (instr == I_SW) begin
                        bus.MemWr = 1'b1;
                        if (bus.mem_ready) begin
                            state_d = FETCH;
                            retire  = 1'b1;
                        end
                    end else begin
                        state_d = FETCH;
                    end
                end
                WB: begin
                    bus.RegWr = writes_reg;
                    state_d   = FETCH;
                    retire    = 1'b1;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.state   = state_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle trace, which is replayed and compared.
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(32)) bus();
    mc_ctrl #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic       rst;
        logic [5:0] op, funct;
        logic       zero, rdy;
        logic [2:0] st;
        logic       rd, wr, irw, pcw, regwr, ill, srcb;
        logic [1:0] pcsrc, ext, aluop, regdst, wdsel;
        logic [31:0] ret;
    } cyc_t;

    typedef struct {
        bit         legal, mem, store, wb, pcw, brz;
        logic [1:0] ext, aluop, regdst, wdsel, pcsrc;
        logic       srcb;
    } ins_t;

    cyc_t q[$];
    cyc_t cur;
    int   m_ret;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Architectural meaning of each encoding.
    function automatic ins_t info(input logic [5:0] o, input logic [5:0] f);
        ins_t d;
        d = '{default: 0};
        case (o)
            6'h00: case (f)
                6'h21: begin d.legal = 1; d.wb = 1; d.regdst = 1; end
                6'h23: begin d.legal = 1; d.wb = 1; d.regdst = 1; d.aluop = 1; end
                6'h08: begin d.legal = 1; d.pcw = 1; d.pcsrc = 3; end
                6'h00: begin d.legal = 1; end
                default: ;
            endcase
            6'h0d: begin d.legal = 1; d.wb = 1; d.srcb = 1; d.aluop = 2; end
            6'h0f: begin d.legal = 1; d.wb = 1; d.srcb = 1; d.aluop = 3; d.ext = 2; end
            6'h23: begin d.legal = 1; d.mem = 1; d.wb = 1; d.ext = 1; d.srcb = 1; d.wdsel = 1; end
            6'h2b: begin d.legal = 1; d.mem = 1; d.store = 1; d.ext = 1; d.srcb = 1; end
            6'h04: begin d.legal = 1; d.pcw = 1; d.brz = 1; d.aluop = 1; d.pcsrc = 1; d.ext = 1; end
            6'h03: begin d.legal = 1; d.pcw = 1; d.wb = 1; d.pcsrc = 2; d.regdst = 2; d.wdsel = 2; end
            default: ;
        endcase
        return d;
    endfunction

    function automatic cyc_t blank(input logic [5:0] o, f, input logic z, rdy, input logic [2:0] st);
        cyc_t c;
        c = '{default: 0};
        c.op = o; c.funct = f; c.zero = z; c.rdy = rdy; c.st = st;
        c.ret = m_ret;
        return c;
    endfunction

    function automatic cyc_t with_sel(input cyc_t c, input ins_t d);
        cyc_t r = c;
        r.ext = d.ext; r.aluop = d.aluop; r.srcb = d.srcb;
        r.regdst = d.regdst; r.wdsel = d.wdsel; r.pcsrc = d.pcsrc;
        return r;
    endfunction

    task automatic push_ins(input logic [5:0] o, f, input logic z, input int fw, mw, input bit rst_in_mem);
        ins_t d;
        cyc_t c;
        d = info(o, f);
        for (int i = 0; i < fw; i++) begin
            c = blank(o, f, z, 0, 0); c.rd = 1; q.push_back(c);
        end
        c = blank(o, f, z, 1, 0); c.rd = 1; c.irw = 1; c.pcw = 1; q.push_back(c);
        c = blank(o, f, z, 1, 1); c.ill = !d.legal; q.push_back(c);
        if (!d.legal) return;
        c = with_sel(blank(o, f, z, 1, 2), d);
        c.pcw = d.pcw && (!d.brz || z);
        q.push_back(c);
        if (!d.mem && !d.wb) begin m_ret++; return; end
        if (d.mem) begin
            for (int i = 0; i < mw; i++) begin
                c = with_sel(blank(o, f, z, 0, 3), d);
                c.rd = !d.store; c.wr = d.store; q.push_back(c);
            end
            if (rst_in_mem) begin
                c = blank(o, f, z, 0, 3); c.rst = 1; q.push_back(c);
                m_ret = 0;
                return;
            end
            c = with_sel(blank(o, f, z, 1, 3), d);
            c.rd = !d.store; c.wr = d.store; q.push_back(c);
            if (d.store) begin m_ret++; return; end
        end
        c = with_sel(blank(o, f, z, 1, 4), d);
        c.regwr = 1;
        q.push_back(c);
        m_ret++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",   bus.state,   cur.st);
            chk("MemRd",   bus.MemRd,   cur.rd);
            chk("MemWr",   bus.MemWr,   cur.wr);
            chk("IRWr",    bus.IRWr,    cur.irw);
            chk("PCWr",    bus.PCWr,    cur.pcw);
            chk("PCSrc",   bus.PCSrc,   cur.pcsrc);
            chk("EXTOp",   bus.EXTOp,   cur.ext);
            chk("ALUSrcB", bus.ALUSrcB, cur.srcb);
            chk("ALUOp",   bus.ALUOp,   cur.aluop);
            chk("RegWr",   bus.RegWr,   cur.regwr);
            chk("RegDst",  bus.RegDst,  cur.regdst);
            chk("WDSel",   bus.WDSel,   cur.wdsel);
            chk("illegal", bus.illegal, cur.ill);
            chk("retired", bus.retired, cur.ret);
        end
    end

    initial begin
        int   n;
        cyc_t c;
        reset = 1'b1;
        bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

        m_ret = 0;
        c = blank(6'h00, 6'h00, 0, 0, 0); c.rst = 1; q.push_back(c);

        n = q.size(); push_ins(6'h0f, 6'h00, 0, 0, 0, 0);
        chk("lui_cycles", q.size() - n, 4);
        chk("lui_ext", q[n+2].ext, 2);
        chk("lui_alu", q[n+2].aluop, 3);
        chk("lui_ret", m_ret, 1);

        n = q.size(); push_ins(6'h23, 6'h00, 0, 2, 2, 0);
        chk("lw_cycles", q.size() - n, 9);
        chk("lw_wdsel", q[n+8].wdsel, 1);

        n = q.size(); push_ins(6'h04, 6'h00, 1, 0, 0, 0);
        chk("beq1_cycles", q.size() - n, 3);
        chk("beq1_pcw", q[n+2].pcw, 1);
        n = q.size(); push_ins(6'h04, 6'h00, 0, 0, 0, 0);
        chk("beq0_pcw", q[n+2].pcw, 0);
        chk("beq_ret", m_ret, 4);

        n = q.size(); push_ins(6'h03, 6'h00, 0, 0, 0, 0);
        chk("jal_regdst", q[n+3].regdst, 2);
        chk("jal_pcsrc", q[n+2].pcsrc, 2);
        push_ins(6'h00, 6'h08, 0, 0, 0, 0);
        push_ins(6'h00, 6'h21, 0, 0, 0, 0);
        push_ins(6'h00, 6'h23, 0, 0, 0, 0);
        push_ins(6'h0d, 6'h00, 0, 1, 0, 0);
        push_ins(6'h00, 6'h00, 0, 0, 0, 0);
        n = q.size(); push_ins(6'h2b, 6'h00, 0, 0, 1, 0);
        chk("sw_cycles", q.size() - n, 5);
        chk("pre_ill_ret", m_ret, 11);

        n = q.size(); push_ins(6'h3f, 6'h00, 0, 0, 0, 0);
        chk("ill_cycles", q.size() - n, 2);
        push_ins(6'h00, 6'h3f, 0, 0, 0, 0);
        chk("ill_ret", m_ret, 11);

        push_ins(6'h2b, 6'h00, 0, 0, 1, 1);
        chk("rst_ret", m_ret, 0);
        push_ins(6'h0f, 6'h00, 0, 0, 0, 0);

        foreach (q[i]) begin
            @(posedge clk); #1;
            reset         = q[i].rst;
            bus.op        = q[i].op;
            bus.funct     = q[i].funct;
            bus.zero      = q[i].zero;
            bus.mem_ready = q[i].rdy;
            cur           = q[i];
            cyc           = i;
            chk_en        = 1'b1;
        end
        @(posedge clk); #1;
        chk_en = 1'b0;
        chk("end_state", bus.state, 0);
        chk("end_retired", bus.retired, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control sequencer for the MIPS datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath select and strobe, including the 2-bit immediate-extender mode.
- Handshakes with a shared instruction/data memory port that may stall.
- Maintains a retired-instruction counter.
- Sits between the IR/PC/regfile/ALU/extender/memory datapath and the top-level CPU wrapper.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- op  in  6  opcode field of the current IR (IR[31:26]).
- funct  in  6  function field of the current IR (IR[5:0]).
- zero  in  1  ALU equality flag, valid in EXEC.
- mem_ready  in  1  memory port completes the current access this cycle.
- MemRd  out  1  memory read request (instruction fetch or lw).
- MemWr  out  1  memory write request (sw).
- IRWr  out  1  IR load strobe.
- PCWr  out  1  PC load strobe.
- PCSrc  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = GPR[rs].
- EXTOp  out  2  0 = zero-extend, 1 = sign-extend, 2 = load-upper (imm<<16).
- ALUSrcB  out  1  0 = GPR[rt], 1 = extended immediate.
- ALUOp  out  2  0 = add, 1 = sub, 2 = or, 3 = pass B.
- RegWr  out  1  register file write strobe.
- RegDst  out  2  0 = rt, 1 = rd, 2 = $31.
- WDSel  out  2  0 = ALU result, 1 = memory data, 2 = PC (already PC+4).
- illegal  out  1  one-cycle pulse in DECODE for an unsupported encoding.
- state  out  3  current state (debug).
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (sync, active-high): state = FETCH(0), retired = 0. While reset is high, all strobes (MemRd, MemWr, IRWr, PCWr, RegWr, illegal) are 0 and all selects are 0. Reset mid-instruction abandons it with no writes.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4. Codes 5–7 go to FETCH next cycle with all strobes 0.
- Decoded set:
  - R-type (op 000000): addu funct 100001, subu 100011, jr 001000, sll funct 000000 (treated as nop).
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, jal 000011.
- Selects (EXTOp, ALUOp, ALUSrcB, RegDst, WDSel, PCSrc) are combinational from state/op/funct. They are held constant for the whole instruction's EXEC/MEM/WB. EXTOp: ori = 0; lw/sw/beq = 1; lui = 2; all others = 0.
- FETCH: MemRd = 1 until mem_ready. In the mem_ready cycle: IRWr = 1, PCWr = 1, PCSrc = 0, next state DECODE. Otherwise stay in FETCH.
- DECODE: no strobes. Illegal encoding: illegal = 1, next FETCH, retired unchanged. Otherwise next EXEC.
- EXEC:
  - addu/subu/ori/lui: ALUOp = add/sub/or/pass, ALUSrcB = 0/0/1/1, next WB.
  - lw/sw: ALUOp = add, ALUSrcB = 1, next MEM.
  - beq: ALUOp = sub, PCSrc = 1, PCWr = zero, next FETCH, retire.
  - jal: PCSrc = 2, PCWr = 1, next WB.
  - jr: PCSrc = 3, PCWr = 1, next FETCH, retire.
  - sll nop: next FETCH, retire.
- MEM:
  - lw: MemRd = 1 until mem_ready, then next WB.
  - sw: MemWr = 1 until mem_ready, then next FETCH and retire in that cycle.
  - MemRd and MemWr are never both 1.
- WB: RegWr = 1 for exactly one cycle, then next FETCH, retire. RegDst/WDSel:
  - addu/subu: 1/0.
  - ori/lui: 0/0.
  - lw: 0/1.
  - jal: 2/2 (WB happens after the jal PC write; WDSel = 2 writes the saved PC+4).
- Retire: retired increments by 1 on the transition into FETCH for every legal instruction. It wraps modulo 2^CNT_W.
- Latency with mem_ready tied to 1:
  - beq/jr/nop: 3 cycles.
  - R/ori/lui/jal: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Each memory wait cycle adds 1.
- PCWr and IRWr never assert outside FETCH, except PCWr in EXEC for beq/jal/jr.

Test Plan:
- Reset then lui (op 001111), mem_ready = 1 → states 0,1,2,4,0; EXTOp = 2 and ALUOp = 3 in EXEC; RegWr = 1 only in WB; retired = 1.
- lw with mem_ready low 2 extra cycles in both FETCH and MEM → MemRd held high through waits; IRWr single pulse; EXTOp = 1; WDSel = 1 in WB; total 9 cycles; retired += 1.
- beq with zero = 1, then with zero = 0 → PCWr = 1 with PCSrc = 1 in EXEC only when zero = 1; 3 cycles each; no RegWr; retired += 2.
- jal then jr → jal: PCWr with PCSrc = 2 in EXEC, then WB with RegDst = 2, WDSel = 2. jr: PCSrc = 3 in EXEC, no RegWr.
- op 111111 → illegal pulses in DECODE; next state FETCH; retired unchanged; no RegWr/MemWr.
- reset asserted in MEM of sw while mem_ready = 0 → next cycle state = 0, MemWr = 0, retired = 0; next fetch proceeds normally.
